// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op encodings, condition-code bit indices and cc type for alu_pipe
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    typedef logic [2:0] cc_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 64
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fn;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    cc_t              out_cc;

    modport master (
        output in_valid, in_fn, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_cc
    );

    modport slave (
        input  in_valid, in_fn, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_cc
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ADD/SUB/AND/XOR with {ZF,SF,OF} flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_fn_e          i_fn,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output cc_t              o_cc
);
    logic w_sa, w_sb, w_sr;

    assign w_sa = i_a[WIDTH-1];
    assign w_sb = i_b[WIDTH-1];
    assign w_sr = o_res[WIDTH-1];

    always_comb begin
        o_res = '0;
        case (i_fn)
            ALU_ADD: o_res = i_a + i_b;
            ALU_SUB: o_res = i_a - i_b;
            ALU_AND: o_res = i_a & i_b;
            ALU_XOR: o_res = i_a ^ i_b;
            default: o_res = '0;
        endcase
    end

    always_comb begin
        o_cc        = '0;
        o_cc[CC_ZF] = (o_res == '0);
        o_cc[CC_SF] = w_sr;
        case (i_fn)
            ALU_ADD: o_cc[CC_OF] = (w_sa == w_sb) && (w_sr != w_sa);
            ALU_SUB: o_cc[CC_OF] = (w_sa != w_sb) && (w_sr != w_sa);
            default: o_cc[CC_OF] = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline feeding an output skid FIFO
// Optional architectural CC register enabled by ALU_PIPE_CC_EN.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus,
    output cc_t       cc_q
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    logic             r_rdy_en;
    logic             r_s1_valid;
    alu_fn_e          r_s1_fn;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_mem_res [FIFO_DEPTH];
    cc_t              r_mem_cc  [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_res;
    cc_t              w_cc;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_occupied;

    assign bus.out_valid = (r_count != '0);
    assign w_pop         = bus.out_valid & bus.out_ready;
    assign w_push        = r_s1_valid;
    // A slot freed by this cycle's pop is reusable at once, sustaining one beat per cycle
    assign w_occupied    = r_count + CW'(r_s1_valid) - CW'(w_pop);
    assign bus.in_ready  = r_rdy_en & (w_occupied < CW'(FIFO_DEPTH));
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign bus.out_res   = bus.out_valid ? r_mem_res[r_rd_ptr] : '0;
    assign bus.out_cc    = bus.out_valid ? r_mem_cc[r_rd_ptr]  : '0;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_fn  (r_s1_fn),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_res (w_res),
        .o_cc  (w_cc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_fn    <= ALU_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_fn <= alu_fn_e'(bus.in_fn);
                r_s1_a  <= bus.in_a;
                r_s1_b  <= bus.in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr] <= w_res;
            r_mem_cc[r_wr_ptr]  <= w_cc;
        end
    end

`ifdef ALU_PIPE_CC_EN
    cc_t r_cc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= '0;
        end else if (w_pop) begin
            r_cc <= bus.out_cc;
        end
    end

    assign cc_q = r_cc;
`else
    assign cc_q = '0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 64;
    localparam int D = 2;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
`ifdef ALU_PIPE_CC_EN
    localparam logic [2:0] CCQ_XOR8 = 3'b010;
`else
    localparam logic [2:0] CCQ_XOR8 = 3'b000;
`endif

    typedef struct {
        logic [63:0] res;
        logic [2:0]  cc;
        int          acc_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe_if #(.WIDTH(8)) bus8 ();
    cc_t cc_q;
    cc_t cc_q8;

    alu_pipe #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cc_q(cc_q)
    );
    alu_pipe #(.WIDTH(8), .FIFO_DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8), .cc_q(cc_q8)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_pop = 0;
    exp_t q[$];
    exp_t e_cmp;
    logic rdy_en;
    logic pop_s;
    logic [2:0] ccm = 3'b000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact signed arithmetic in 66 bits; overflow means the wrapped result differs
    function automatic exp_t model(input int fn, input logic [63:0] a, input logic [63:0] b);
        exp_t r;
        logic signed [65:0] sa, sb, t, back;
        sa = $signed(a);
        sb = $signed(b);
        case (fn)
            0:       t = sa + sb;
            1:       t = sa - sb;
            2:       t = {2'b00, a & b};
            default: t = {2'b00, a ^ b};
        endcase
        r.res     = t[63:0];
        back      = $signed(r.res);
        r.cc      = {r.res == 64'd0, r.res[63], (fn < 2) && (t != back)};
        r.acc_cyc = 0;
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return MAXV;
            2:       return MINV;
            3:       return {64{1'b1}};
            4:       return 64'd1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ccm = 3'b000;
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("rst_out_res", bus.out_res, 64'd0);
            check("rst_cc_q", 64'(cc_q), 64'd0);
        end else begin
            pop_s = bus.out_valid && bus.out_ready;
            check("in_ready", 64'(bus.in_ready),
                  64'(rdy_en && ((q.size() - int'(pop_s)) < D)));
            check("cc_q", 64'(cc_q), 64'(ccm));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got res 0x%0h, required no output", bus.out_res);
                end else begin
                    check("out_res", bus.out_res, q[0].res);
                    check("out_cc", 64'(bus.out_cc), 64'(q[0].cc));
                    check("latency_ge2", 64'((cyc - q[0].acc_cyc) >= 2), 64'd1);
                    if (pop_s) begin
`ifdef ALU_PIPE_CC_EN
                        ccm = q[0].cc;
`endif
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end else begin
                check("idle_out_res", bus.out_res, 64'd0);
                check("idle_out_cc", 64'(bus.out_cc), 64'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                e_cmp         = model(int'(bus.in_fn), bus.in_a, bus.in_b);
                e_cmp.acc_cyc = cyc;
                q.push_back(e_cmp);
            end
        end
    end

    task automatic send(input int fn, input logic [63:0] a, input logic [63:0] b);
        int   budget;
        logic ok;
        budget = 0;
        ok     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_fn    = 2'(fn);
        bus.in_a     = a;
        bus.in_b     = b;
        while (!ok && budget < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            budget++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no in_ready in %0d cycles, required acceptance", budget);
        end
    endtask

    task automatic expect_out(input string name, input logic [63:0] res, input logic [2:0] cc,
                              output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 50);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_res"}, bus.out_res, res);
        check({name, "_cc"}, 64'(bus.out_cc), 64'(cc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   lat, acc, nv, p0;
        logic ok;

        bus.in_valid   = 1'b0;
        bus.in_fn      = 2'd0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_fn     = 2'd0;
        bus8.in_a      = '0;
        bus8.in_b      = '0;
        bus8.out_ready = 1'b0;

        e = model(0, MAXV, 64'd1);
        check("model_add_ovf_res", e.res, MINV);
        check("model_add_ovf_cc", 64'(e.cc), 64'(3'b011));
        e = model(1, 64'd5, 64'd5);
        check("model_sub_zero", {e.res[60:0], e.cc}, {61'd0, 3'b100});
        e = model(1, MINV, 64'd1);
        check("model_sub_ovf", e.res, MAXV);
        check("model_sub_ovf_cc", 64'(e.cc), 64'(3'b001));

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 check("ready_after_edge", 64'(bus.in_ready), 64'd1);

        bus.out_ready = 1'b1;
        send(0, MAXV, 64'd1);
        expect_out("add_ovf", MINV, 3'b011, lat);
        check("add_latency", 64'(lat), 64'd2);
        send(1, 64'd5, 64'd5);
        expect_out("sub_zero", 64'd0, 3'b100, lat);
        send(1, MINV, 64'd1);
        expect_out("sub_ovf", MAXV, 3'b001, lat);

        bus8.out_ready = 1'b1;
        bus8.in_fn     = 2'd3;
        bus8.in_a      = 8'hFF;
        bus8.in_b      = 8'h0F;
        bus8.in_valid  = 1'b1;
        @(negedge clk);
        check("x8_ready", 64'(bus8.in_ready), 64'd1);
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus8.out_valid && lat < 20);
        check("x8_latency", 64'(lat), 64'd2);
        check("x8_res", 64'(bus8.out_res), 64'h00F0);
        check("x8_cc", 64'(bus8.out_cc), 64'(3'b010));
        @(posedge clk);
        #1 check("x8_cc_q", 64'(cc_q8), 64'(CCQ_XOR8));

        bus.out_ready = 1'b0;
        acc = 0;
        p0  = n_pop;
        bus.in_valid = 1'b1;
        bus.in_fn    = 2'd0;
        bus.in_a     = pick();
        bus.in_b     = pick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) acc++;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.in_a = pick();
                bus.in_b = pick();
            end
        end
        check("bp_accepts_stalled", 64'(acc), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && acc < 5; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) acc++;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.in_a = pick();
                bus.in_b = pick();
            end
        end
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("bp_all_out", 64'(n_pop - p0), 64'd5);

        bus.out_ready = 1'b0;
        send(0, 64'd1, 64'd2);
        send(0, 64'd3, 64'd4);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        check("arst_out_res", bus.out_res, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("no_stale", 64'(nv), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!bus.in_valid || ok) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.in_fn    = 2'($urandom_range(0, 3));
                bus.in_a     = pick();
                bus.in_b     = pick();
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("drain_empty", 64'(q.size()), 64'd0);

        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_fn    = 2'($urandom_range(0, 3));
        bus.in_a     = pick();
        bus.in_b     = pick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) acc++;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.in_fn = 2'($urandom_range(0, 3));
                bus.in_a  = pick();
                bus.in_b  = pick();
            end
        end
        bus.in_valid = 1'b0;
        check("throughput", 64'(acc), 64'd20);
        repeat (6) @(posedge clk);
        #1 check("final_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits (legal 8..64).
REQ-002 Parameter FIFO_DEPTH, default 2, output skid-buffer entries (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_fn  input  2  op: 0 ADD, 1 SUB, 2 AND, 3 XOR.
REQ-008 in_a, in_b  input  WIDTH each  signed operands.
REQ-009 out_valid  output  1  result beat available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_res  output  WIDTH  result.
REQ-012 out_cc  output  3  {ZF, SF, OF} for out_res.
REQ-013 cc_q  output  3  architectural condition-code register (see Configuration).

Function
REQ-014 Transfer occurs on a cycle where valid and ready are both high; no other cycle transfers.
REQ-015 ADD = a + b; SUB = a - b; AND/XOR bitwise; result truncated to WIDTH bits (wrap-around).
REQ-016 ZF = (res == 0); SF = res[WIDTH-1]; OF for ADD = sign(a)==sign(b) and sign(res)!=sign(a); OF for SUB = sign(a)!=sign(b) and sign(res)!=sign(a); OF = 0 for AND/XOR.
REQ-017 Stage 1 registers the accepted operands and fn; stage 2 registers result and flags into the skid FIFO; minimum latency accept-to-out_valid = 2 cycles.
REQ-018 Throughput one beat per cycle while out_ready held high.
REQ-019 in_ready = FIFO entries occupied plus in-flight beats < FIFO_DEPTH; no beat is ever dropped or duplicated.
REQ-020 Results emerge in acceptance order.
REQ-021 out_res/out_cc hold stable while out_valid=1 and out_ready=0.
REQ-022 FIFO full with simultaneous push and pop: both occur, count unchanged.
REQ-023 FIFO empty: out_valid=0, out_res/out_cc = 0.
REQ-024 Pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 rst_n low asynchronously clears all valid bits, FIFO pointers/count, cc_q; out_valid=0, in_ready=0 during reset, out_res/out_cc=0.
REQ-026 in_ready rises on the first clk edge after rst_n deasserts; in-flight beats at reset are discarded.

Configuration
REQ-027 Macro ALU_PIPE_CC_EN: when defined, cc_q loads out_cc on each output transfer with fn ADD or SUB (AND/XOR also load, per Y86 OPq semantics) — i.e. every output transfer.
REQ-028 Without ALU_PIPE_CC_EN, no CC register is built and cc_q is tied to 3'b000.

Structure
REQ-029 Package alu_pkg holds op encodings (ALU_ADD..ALU_XOR), flag bit indices (CC_ZF=2, CC_SF=1, CC_OF=0) and the cc type.
REQ-030 Sub-module alu_core: combinational WIDTH-parametrised op and flag computation, instanced once between stage 1 and stage 2.

Verification
REQ-031 WIDTH=64, ADD a=9223372036854775807, b=1 -> res=-9223372036854775808, cc=3'b011 two cycles after accept.
REQ-032 SUB a=5, b=5 -> res=0, cc=3'b100; SUB a=-9223372036854775808, b=1 -> res=9223372036854775807, cc=3'b001.
REQ-033 out_ready=0, push 5 ADDs back-to-back with FIFO_DEPTH=2 -> in_ready falls after 2 accepts; release out_ready -> all accepted results in order, none lost.
REQ-034 rst_n pulsed low mid-stream with 2 beats in flight -> out_valid=0 immediately, no stale result after reset.
REQ-035 WIDTH=8, XOR a=8'hFF, b=8'h0F -> res=8'hF0, cc=3'b010; with ALU_PIPE_CC_EN cc_q=3'b010 after transfer, without it cc_q=0.
